// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - two-master round-robin arbiter for the single memory-mapped I/O port
// One transaction in flight; loads return data with a one-cycle rvalid pulse.
`ifndef IO_LOAD
`define IO_LOAD 1'b0
`endif
`ifndef IO_STORE
`define IO_STORE 1'b1
`endif

module io_bus_arbiter #(
  parameter int DBITS      = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m0_req,
  input  logic [DBITS-1:0] m0_addr,
  input  logic [DBITS-1:0] m0_wdata,
  input  logic             m0_we,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [DBITS-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic [DBITS-1:0] m1_addr,
  input  logic [DBITS-1:0] m1_wdata,
  input  logic             m1_we,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [DBITS-1:0] m1_rdata,
  output logic [DBITS-1:0] bus_addr,
  output logic [DBITS-1:0] bus_wdata,
  output logic             bus_load_store,
  output logic             bus_valid,
  input  logic [DBITS-1:0] bus_rdata
);

  localparam int CW = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             ptr_q, ptr_d;
  logic             we_q, we_d;
  logic [DBITS-1:0] addr_q, addr_d;
  logic [DBITS-1:0] wdata_q, wdata_d;
  logic [DBITS-1:0] rdata0_q, rdata0_d;
  logic [DBITS-1:0] rdata1_q, rdata1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rv0_q, rv0_d;
  logic             rv1_q, rv1_d;
  logic             pick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sel_q    <= 1'b0;
      ptr_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cnt_q    <= '0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cnt_q    <= cnt_d;
      rv0_q    <= rv0_d;
      rv1_q    <= rv1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    cnt_d    = cnt_q;
    rv0_d    = 1'b0;
    rv1_d    = 1'b0;
    // When both request, the master that was not granted last wins.
    pick     = (m0_req && m1_req) ? ~ptr_q : m1_req;
    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          sel_d   = pick;
          ptr_d   = pick;
          addr_d  = pick ? m1_addr  : m0_addr;
          wdata_d = pick ? m1_wdata : m0_wdata;
          we_d    = pick ? m1_we    : m0_we;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = CW'(RD_LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (sel_q) begin
            rdata1_d = bus_rdata;
            rv1_d    = 1'b1;
          end else begin
            rdata0_d = bus_rdata;
            rv0_d    = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus_valid      = (state_q == S_ISSUE);
  assign bus_addr       = addr_q;
  assign bus_wdata      = wdata_q;
  assign bus_load_store = (bus_valid && we_q) ? `IO_STORE : `IO_LOAD;
  assign m0_gnt         = bus_valid && !sel_q;
  assign m1_gnt         = bus_valid && sel_q;
  assign m0_rvalid      = rv0_q;
  assign m1_rvalid      = rv1_q;
  assign m0_rdata       = rdata0_q;
  assign m1_rdata       = rdata1_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - randomized bench for io_bus_arbiter against a transaction-timing model
`ifndef IO_LOAD
`define IO_LOAD 1'b0
`endif
`ifndef IO_STORE
`define IO_STORE 1'b1
`endif

module tb_io_bus_arbiter;
  localparam int L    = 3;
  localparam int NCYC = 2000;
  localparam int MAXC = NCYC + L + 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_load_store, bus_valid;

  logic        mreq[2];
  logic [31:0] maddr[2];
  logic [31:0] mwdata[2];
  logic        mwe[2];

  io_bus_arbiter #(.DBITS(32), .RD_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .m0_req(mreq[0]), .m0_addr(maddr[0]), .m0_wdata(mwdata[0]), .m0_we(mwe[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(mreq[1]), .m1_addr(maddr[1]), .m1_wdata(mwdata[1]), .m1_we(mwe[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_load_store(bus_load_store),
    .bus_valid(bus_valid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp, input int c);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, c, got, exp);
    end
  endtask

  // Expected per-cycle bus activity, keyed by cycle number.
  bit          e_valid[MAXC];
  bit          e_sel[MAXC];
  bit          e_we[MAXC];
  logic [31:0] e_addr[MAXC];
  logic [31:0] e_wdata[MAXC];
  bit          e_rv[2][MAXC];
  int          e_src[MAXC];
  logic [31:0] hist[MAXC];
  logic [31:0] mdata[2];

  task automatic check_reset_outputs(input int c);
    check_eq("rst_bus_valid", 32'(bus_valid), 32'd0, c);
    check_eq("rst_load_store", 32'(bus_load_store), 32'(`IO_LOAD), c);
    check_eq("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0, c);
    check_eq("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0, c);
    check_eq("rst_m0_rdata", m0_rdata, 32'd0, c);
    check_eq("rst_m1_rdata", m1_rdata, 32'd0, c);
    check_eq("rst_bus_addr", bus_addr, 32'd0, c);
    check_eq("rst_bus_wdata", bus_wdata, 32'd0, c);
  endtask

  initial begin
    int  free_c;
    int  last;
    int  next_rst;
    int  p;
    int  w;
    bit  rst_now;
    bit  gseen[2];

    free_c = 0; last = 0; next_rst = 250;
    gseen[0] = 0; gseen[1] = 0;
    mdata[0] = '0; mdata[1] = '0;
    reset = 1'b1; bus_rdata = '0;
    for (int m = 0; m < 2; m++) begin
      mreq[m] = 1'b0; maddr[m] = '0; mwdata[m] = '0; mwe[m] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(-1);

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      rst_now = (c >= next_rst) && ((free_c > c + 2) || (c >= next_rst + 50));
      bus_rdata = $urandom;
      hist[c]   = bus_rdata;
      if (rst_now) begin
        reset = 1'b1;
        for (int m = 0; m < 2; m++) begin
          mreq[m] = 1'b0;
          gseen[m] = 0;
        end
        next_rst = c + 300 + int'($urandom_range(0, 99));
      end else begin
        reset = 1'b0;
        p = (c >= 800 && c < 1100) ? 100 : 35;
        for (int m = 0; m < 2; m++) begin
          if (!mreq[m] || gseen[m]) begin
            gseen[m] = 0;
            if (int'($urandom_range(0, 99)) < p) begin
              mreq[m] = 1'b1;
              case ($urandom_range(0, 3))
                0:       maddr[m] = 32'h0000_0010;
                1:       maddr[m] = 32'hF000_0014;
                default: maddr[m] = $urandom;
              endcase
              mwdata[m] = ($urandom_range(0, 3) == 0) ? 32'h0000_DEAD : $urandom;
              mwe[m]    = $urandom_range(0, 1) == 1;
            end else begin
              mreq[m] = 1'b0;
            end
          end
        end
      end

      @(negedge clk);
      if (rst_now) begin
        check_reset_outputs(c);
        for (int i = c + 1; i < MAXC; i++) begin
          e_valid[i] = 0; e_rv[0][i] = 0; e_rv[1][i] = 0;
        end
        free_c = c + 1;
        last = 0;
        mdata[0] = '0; mdata[1] = '0;
      end else begin
        for (int m = 0; m < 2; m++)
          if (e_rv[m][c]) mdata[m] = hist[e_src[c]];
        check_eq("bus_valid", 32'(bus_valid), 32'(e_valid[c]), c);
        check_eq("bus_load_store", 32'(bus_load_store),
                 32'((e_valid[c] && e_we[c]) ? `IO_STORE : `IO_LOAD), c);
        check_eq("m0_gnt", 32'(m0_gnt), 32'(e_valid[c] && !e_sel[c]), c);
        check_eq("m1_gnt", 32'(m1_gnt), 32'(e_valid[c] && e_sel[c]), c);
        check_eq("m0_rvalid", 32'(m0_rvalid), 32'(e_rv[0][c]), c);
        check_eq("m1_rvalid", 32'(m1_rvalid), 32'(e_rv[1][c]), c);
        check_eq("m0_rdata", m0_rdata, mdata[0], c);
        check_eq("m1_rdata", m1_rdata, mdata[1], c);
        if (e_valid[c]) begin
          check_eq("bus_addr", bus_addr, e_addr[c], c);
          check_eq("bus_wdata", bus_wdata, e_wdata[c], c);
          gseen[e_sel[c] ? 1 : 0] = 1;
        end
        // Arbiter samples requests only when idle; grant and issue follow one cycle later.
        if (c >= free_c && (mreq[0] || mreq[1])) begin
          w = (mreq[0] && mreq[1]) ? 1 - last : (mreq[1] ? 1 : 0);
          last = w;
          e_valid[c+1] = 1;
          e_sel[c+1]   = (w == 1);
          e_addr[c+1]  = maddr[w];
          e_wdata[c+1] = mwdata[w];
          e_we[c+1]    = mwe[w];
          if (mwe[w]) begin
            free_c = c + 2;
          end else begin
            e_rv[w][c+2+L] = 1;
            e_src[c+2+L]   = c + 1 + L;
            free_c = c + 2 + L;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
